// File: rtl/down_timer8_pkg.sv
// Shared constants for the down_timer8 block: default width and FSM state encodings.
package down_timer8_pkg;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/down_timer8_if.sv
// Control/status bundle for down_timer8; slave side is the timer, master side the controller.
interface down_timer8_if import down_timer8_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (output load, load_val, start, stop, auto_reload,
                  input  count, tc, busy, done);
  modport slave  (input  load, load_val, start, stop, auto_reload,
                  output count, tc, busy, done);
endinterface

// File: rtl/down_timer8_tick_prescaler.sv
// Modulo-PRESCALE enable divider; counter held at zero while en is low.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign tick     = en;
    end else begin : g_div
      localparam int CW = $clog2(PRESCALE);
      logic [CW-1:0] r_cnt;
      logic          w_last;

      assign w_last = (r_cnt == CW'(PRESCALE - 1));
      assign tick   = en && w_last;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_cnt <= '0;
        else if (!en || w_last)  r_cnt <= '0;
        else                     r_cnt <= r_cnt + CW'(1);
      end
    end
  endgenerate
endmodule

// File: rtl/down_timer8.sv
// Loadable, pausable down-counting timer with one-shot or auto-reload terminal count.
module down_timer8 import down_timer8_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  down_timer8_if.slave bus
);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             w_pre_en;
  logic             w_tick;

  // load/stop take the edge, so the prescaler restarts from zero on the next run
  assign w_pre_en = (r_state == ST_RUN) && !bus.load && !bus.stop;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_pre_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (bus.load) begin
        r_count  <= bus.load_val;
        r_reload <= bus.load_val;
        r_state  <= ST_IDLE;
      end else if (bus.stop) begin
        if (r_state == ST_RUN) r_state <= ST_IDLE;
      end else if (bus.start && r_state != ST_RUN) begin
        if (r_state == ST_IDLE) begin
          if (r_count != '0) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_DONE;
            r_tc    <= 1'b1;
          end
        end else begin
          // restart from DONE; a zero reload is another zero-length timeout
          r_count <= r_reload;
          if (r_reload != '0) r_state <= ST_RUN;
          else                r_tc    <= 1'b1;
        end
      end else if (r_state == ST_RUN && w_tick) begin
        if (r_count == WIDTH'(1)) begin
          r_tc <= 1'b1;
          if (bus.auto_reload) begin
            r_count <= r_reload;
          end else begin
            r_count <= '0;
            r_state <= ST_DONE;
          end
        end else begin
          r_count <= r_count - WIDTH'(1);
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.busy  = (r_state == ST_RUN);
  assign bus.done  = (r_state == ST_DONE);
endmodule

// File: tb/tb_down_timer8.sv
// Vector-table and scoreboard bench for down_timer8 (PRESCALE=1 and PRESCALE=4 instances).
module tb_down_timer8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  down_timer8_if #(.WIDTH(8)) b1 ();
  down_timer8_if #(.WIDTH(8)) b4 ();

  down_timer8 #(.WIDTH(8), .PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  down_timer8 #(.WIDTH(8), .PRESCALE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       sp;
    logic       ar;
    logic [7:0] ec;
    logic       e_tc;
    logic       eb;
    logic       ed;
    string      nm;
  } vec_t;

  typedef struct {
    bit         sel;
    logic [10:0] exp;
    string      nm;
  } sb_t;

  vec_t tv[$];
  sb_t  sbq[$];

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
               nm, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [10:0] obs(input bit sel);
    if (sel) return {b4.count, b4.tc, b4.busy, b4.done};
    return {b1.count, b1.tc, b1.busy, b1.done};
  endfunction

  task automatic drive_idle();
    b1.load = 0; b1.load_val = 0; b1.start = 0; b1.stop = 0; b1.auto_reload = 0;
    b4.load = 0; b4.load_val = 0; b4.start = 0; b4.stop = 0; b4.auto_reload = 0;
  endtask

  // one clock: drive at negedge, queue the expectation, compare after the posedge
  task automatic cyc(input bit sel, input vec_t v);
    sb_t e;
    @(negedge clk);
    drive_idle();
    if (sel) begin
      b4.load = v.ld; b4.load_val = v.lv; b4.start = v.st; b4.stop = v.sp; b4.auto_reload = v.ar;
    end else begin
      b1.load = v.ld; b1.load_val = v.lv; b1.start = v.st; b1.stop = v.sp; b1.auto_reload = v.ar;
    end
    sbq.push_back('{sel, {v.ec, v.e_tc, v.eb, v.ed}, v.nm});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk(e.nm, obs(e.sel), e.exp);
  endtask

  function automatic vec_t V(input logic ld, input logic [7:0] lv, input logic st, input logic sp,
                             input logic ar, input logic [7:0] ec, input logic e_tc,
                             input logic eb, input logic ed, input string nm);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ar = ar;
    v.ec = ec; v.e_tc = e_tc; v.eb = eb; v.ed = ed; v.nm = nm;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", obs(0), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release", obs(0), 11'd0);

    // one-shot 5, restart from DONE, auto-reload 3, pause/resume 10
    //                ld lv  st sp ar  ec  tc b  d
    tv.push_back(V(1, 5,  0, 0, 0, 5,  0, 0, 0, "os_load"));
    tv.push_back(V(0, 0,  1, 0, 0, 5,  0, 1, 0, "os_start"));
    tv.push_back(V(0, 0,  0, 0, 0, 4,  0, 1, 0, "os_4"));
    tv.push_back(V(0, 0,  0, 0, 0, 3,  0, 1, 0, "os_3"));
    tv.push_back(V(0, 0,  0, 0, 0, 2,  0, 1, 0, "os_2"));
    tv.push_back(V(0, 0,  0, 0, 0, 1,  0, 1, 0, "os_1"));
    tv.push_back(V(0, 0,  0, 0, 0, 0,  1, 0, 1, "os_tc"));
    tv.push_back(V(0, 0,  0, 0, 0, 0,  0, 0, 1, "os_done"));
    tv.push_back(V(0, 0,  1, 0, 0, 5,  0, 1, 0, "done_restart"));
    tv.push_back(V(1, 3,  0, 0, 1, 3,  0, 0, 0, "ar_load"));
    tv.push_back(V(0, 0,  1, 0, 1, 3,  0, 1, 0, "ar_start"));
    tv.push_back(V(0, 0,  0, 0, 1, 2,  0, 1, 0, "ar_2"));
    tv.push_back(V(0, 0,  0, 0, 1, 1,  0, 1, 0, "ar_1"));
    tv.push_back(V(0, 0,  0, 0, 1, 3,  1, 1, 0, "ar_tc1"));
    tv.push_back(V(0, 0,  0, 0, 1, 2,  0, 1, 0, "ar_2b"));
    tv.push_back(V(0, 0,  0, 0, 1, 1,  0, 1, 0, "ar_1b"));
    tv.push_back(V(0, 0,  0, 0, 1, 3,  1, 1, 0, "ar_tc2"));
    tv.push_back(V(1, 10, 0, 0, 0, 10, 0, 0, 0, "pr_load"));
    tv.push_back(V(0, 0,  1, 0, 0, 10, 0, 1, 0, "pr_start"));
    for (int i = 9; i >= 6; i--) tv.push_back(V(0, 0, 0, 0, 0, 8'(i), 0, 1, 0, "pr_run"));
    tv.push_back(V(0, 0,  0, 1, 0, 6,  0, 0, 0, "pr_stop"));
    for (int i = 0; i < 4; i++) tv.push_back(V(0, 0, 0, 0, 0, 6, 0, 0, 0, "pr_held"));
    tv.push_back(V(0, 0,  1, 0, 0, 6,  0, 1, 0, "pr_resume"));
    tv.push_back(V(0, 0,  0, 0, 0, 5,  0, 1, 0, "pr_5"));
    tv.push_back(V(0, 0,  0, 0, 0, 4,  0, 1, 0, "pr_4"));
    foreach (tv[i]) cyc(0, tv[i]);

    // zero-length timeouts and load colliding with the terminal tick
    cyc(0, V(1, 0,   0, 0, 0, 0,   0, 0, 0, "z_load"));
    cyc(0, V(0, 0,   1, 0, 0, 0,   1, 0, 1, "z_start_tc"));
    cyc(0, V(0, 0,   0, 0, 0, 0,   0, 0, 1, "z_tc_drop"));
    cyc(0, V(0, 0,   1, 0, 0, 0,   1, 0, 1, "z_done_restart"));
    cyc(0, V(1, 2,   0, 0, 0, 2,   0, 0, 0, "c_load"));
    cyc(0, V(0, 0,   1, 0, 0, 2,   0, 1, 0, "c_start"));
    cyc(0, V(0, 0,   0, 0, 0, 1,   0, 1, 0, "c_1"));
    cyc(0, V(1, 200, 0, 0, 0, 200, 0, 0, 0, "c_load_wins"));
    cyc(0, V(0, 0,   0, 0, 0, 200, 0, 0, 0, "c_no_tc"));

    // prescale 4: one decrement per 4 cycles, tc 8 cycles after start
    cyc(1, V(1, 2, 0, 0, 0, 2, 0, 0, 0, "ps_load"));
    cyc(1, V(0, 0, 1, 0, 0, 2, 0, 1, 0, "ps_start"));
    for (int i = 1; i <= 8; i++)
      cyc(1, V(0, 0, 0, 0, 0, (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0,
               (i == 8), (i < 8), (i == 8), $sformatf("ps_cyc%0d", i)));

    // asynchronous reset in the middle of a run
    cyc(0, V(1, 50, 0, 0, 0, 50, 0, 0, 0, "rr_load"));
    cyc(0, V(0, 0,  1, 0, 0, 50, 0, 1, 0, "rr_start"));
    cyc(0, V(0, 0,  0, 0, 0, 49, 0, 1, 0, "rr_49"));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rr_async", obs(0), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, V(0, 0, 0, 0, 0, 0, 0, 0, 0, "rr_after"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
